// File: rtl/wdg_pkg.sv
// rtl/wdg_pkg.sv - service keys and state encodings for the watchdog service block
package wdg_pkg;

    localparam logic [31:0] KEY1 = 32'h5A5A_A5A5;
    localparam logic [31:0] KEY2 = 32'hA5A5_5A5A;

    typedef enum logic {
        WAIT_K1 = 1'b0,
        WAIT_K2 = 1'b1
    } key_state_e;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        BARK = 2'd1,
        BITE = 2'd2
    } main_state_e;

endpackage

// File: rtl/wdg_keyseq.sv
// rtl/wdg_keyseq.sv - two-key service sequencer with KEY1-to-KEY2 timeout
module wdg_keyseq
    import wdg_pkg::*;
#(
    parameter int KEY_TO = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic        seq_done,
    output logic        seq_err
);

    localparam int TW = $clog2(KEY_TO + 1);

    key_state_e    state_q, state_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= WAIT_K1;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // A write in the last allowed cycle still counts as the KEY2 attempt.
    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        seq_done = 1'b0;
        seq_err  = 1'b0;
        if (state_q == WAIT_K1) begin
            if (wr_en) begin
                if (wr_data == KEY1) begin
                    state_d  = WAIT_K2;
                    to_cnt_d = '0;
                end else begin
                    seq_err = 1'b1;
                end
            end
        end else begin
            if (wr_en) begin
                state_d  = WAIT_K1;
                to_cnt_d = '0;
                if (wr_data == KEY2) begin
                    seq_done = 1'b1;
                end else begin
                    seq_err = 1'b1;
                end
            end else if (to_cnt_q == TW'(KEY_TO - 1)) begin
                state_d  = WAIT_K1;
                to_cnt_d = '0;
                seq_err  = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wdg_service.sv
// rtl/wdg_service.sv - watchdog service: window check, bark/bite escalation
module wdg_service
    import wdg_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int KEY_TO = 16
) (
    input  logic             sys_clk,
    input  logic             res,
    input  logic             wr_en,
    input  logic [31:0]      wr_data,
    input  logic [WIDTH-1:0] count_wdg,
    input  logic [WIDTH-1:0] cnt_thrhd,
    input  logic [WIDTH-1:0] win_thrhd,
    output logic             cnt_clr,
    output logic             kick_ok,
    output logic             kick_err,
    output logic             bark,
    output logic             bite
);

    logic        seq_done, seq_err;
    main_state_e state_q, state_d;
    logic        eq_q, eq_d;
    logic        cnt_clr_q, cnt_clr_d;
    logic        kick_ok_q, kick_ok_d;
    logic        kick_err_q, kick_err_d;
    logic        expiry, window_ok, accept;

    wdg_keyseq #(.KEY_TO(KEY_TO)) u_keyseq (
        .clk      (sys_clk),
        .rst      (res),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .seq_done (seq_done),
        .seq_err  (seq_err)
    );

    // eq_q starts at 1 so a count already parked at threshold is not an expiry.
    always_ff @(posedge sys_clk or posedge res) begin
        if (res) begin
            state_q    <= RUN;
            eq_q       <= 1'b1;
            cnt_clr_q  <= 1'b0;
            kick_ok_q  <= 1'b0;
            kick_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            eq_q       <= eq_d;
            cnt_clr_q  <= cnt_clr_d;
            kick_ok_q  <= kick_ok_d;
            kick_err_q <= kick_err_d;
        end
    end

    always_comb begin
        eq_d       = (count_wdg == cnt_thrhd);
        expiry     = eq_d && !eq_q;
        window_ok  = (win_thrhd <= cnt_thrhd) && (count_wdg >= win_thrhd);
        accept     = seq_done && window_ok && (state_q != BITE);
        state_d    = state_q;
        kick_ok_d  = accept;
        cnt_clr_d  = accept;
        kick_err_d = seq_err || (seq_done && !accept);
        case (state_q)
            RUN: begin
                if (!accept && expiry) state_d = BARK;
            end
            BARK: begin
                if (accept)      state_d = RUN;
                else if (expiry) state_d = BITE;
            end
            BITE: begin
                kick_err_d = wr_en;
            end
            default: state_d = RUN;
        endcase
    end

    assign cnt_clr  = cnt_clr_q;
    assign kick_ok  = kick_ok_q;
    assign kick_err = kick_err_q;
    assign bark     = (state_q != RUN);
    assign bite     = (state_q == BITE);

endmodule
